// File: rtl/game_pkg.sv
// Shared types and constants for the falling-block game blocks.
package game_pkg;

  localparam int unsigned NUM_BLOCKS     = 10;
  localparam int unsigned FRAMES_PER_SEC = 60;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN      = 3'd1,
    DRAIN      = 3'd2,
    LEVEL_DONE = 3'd3,
    GAME_OVER  = 3'd4,
    WIN        = 3'd5
  } sched_state_t;

endpackage

// File: rtl/edge_detect.sv
// Remembers last cycle's value of a level signal and flags a rising or falling
// transition in the current cycle.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1,
  parameter logic FALLING   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_edge_c
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= RESET_VAL;
    else       r_prev <= i_sig;
  end

  assign o_edge_c = FALLING ? (~i_sig & r_prev) : (i_sig & ~r_prev);

endmodule

// File: rtl/block_scheduler.sv
// Frame-synchronous sequencer: releases blocks per level, retires them on end_level,
// stops the round on collision and keeps the elapsed-seconds count.
module block_scheduler #(
  parameter int unsigned NUM_BLOCKS     = game_pkg::NUM_BLOCKS,
  parameter int unsigned SPAWN_GAP      = 45,
  parameter int unsigned FRAMES_PER_SEC = game_pkg::FRAMES_PER_SEC,
  parameter int unsigned SEC_MAX        = 999
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  vs,
  input  logic                  Run,
  input  logic [1:0]            Collision,
  input  logic [NUM_BLOCKS-1:0] end_level,
  output logic [NUM_BLOCKS-1:0] block_ready,
  output logic                  level_one,
  output logic                  level_two,
  output logic [9:0]            seconds,
  output logic                  game_over,
  output logic                  win
);

  import game_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 1);
  localparam int unsigned FRM_W = $clog2(FRAMES_PER_SEC + 1);
  localparam int unsigned SEC_W = 10;
  localparam logic [GAP_W-1:0] GAP_L1 = GAP_W'(SPAWN_GAP);
  localparam logic [GAP_W-1:0] GAP_L2 = GAP_W'(SPAWN_GAP / 2);

  sched_state_t          r_state, w_state_nxt;
  logic [NUM_BLOCKS-1:0] r_block_ready, w_ready_nxt, w_release;
  logic [IDX_W-1:0]      r_next_idx, w_idx_nxt;
  logic [GAP_W-1:0]      r_gap, w_gap_nxt;
  logic [FRM_W-1:0]      r_frame, w_frame_nxt;
  logic [SEC_W-1:0]      r_seconds, w_sec_nxt;
  logic                  r_level2, w_level2_nxt;
  logic                  r_level_one, r_level_two, r_game_over, r_win;
  logic                  w_tick, w_run_edge, w_in_play, w_in_round_nxt;

  // vs history resets high so the first falling edge after reset counts as a tick.
  edge_detect #(.RESET_VAL(1'b1), .FALLING(1'b1)) u_vs_edge (
    .i_clk(Clk), .i_rst(Reset), .i_sig(vs), .o_edge_c(w_tick)
  );

  // Run history resets high so Run held through reset cannot start a round.
  edge_detect #(.RESET_VAL(1'b1), .FALLING(1'b0)) u_run_edge (
    .i_clk(Clk), .i_rst(Reset), .i_sig(Run), .o_edge_c(w_run_edge)
  );

  assign w_in_play      = (r_state == SPAWN) || (r_state == DRAIN);
  assign w_release      = NUM_BLOCKS'(1) << r_next_idx;
  assign w_in_round_nxt = (w_state_nxt == SPAWN) || (w_state_nxt == DRAIN) ||
                          (w_state_nxt == LEVEL_DONE);

  always_comb begin
    w_state_nxt  = r_state;
    w_ready_nxt  = r_block_ready;
    w_idx_nxt    = r_next_idx;
    w_gap_nxt    = r_gap;
    w_frame_nxt  = r_frame;
    w_sec_nxt    = r_seconds;
    w_level2_nxt = r_level2;

    if (w_in_play && w_tick) begin
      if (r_frame == FRM_W'(FRAMES_PER_SEC - 1)) begin
        w_frame_nxt = '0;
        if (r_seconds != SEC_W'(SEC_MAX)) w_sec_nxt = r_seconds + SEC_W'(1);
      end else begin
        w_frame_nxt = r_frame + FRM_W'(1);
      end
    end

    case (r_state)
      IDLE: begin
        w_ready_nxt  = '0;
        w_level2_nxt = 1'b0;
        w_frame_nxt  = '0;
        w_sec_nxt    = '0;
        if (w_run_edge) begin
          w_state_nxt = SPAWN;
          w_idx_nxt   = '0;
          w_gap_nxt   = GAP_W'(1);
        end
      end
      SPAWN: begin
        w_ready_nxt = r_block_ready & ~end_level;
        if (w_tick) begin
          if (r_gap <= GAP_W'(1)) begin
            w_ready_nxt = w_ready_nxt | w_release;
            w_idx_nxt   = r_next_idx + IDX_W'(1);
            w_gap_nxt   = r_level2 ? GAP_L2 : GAP_L1;
            if (r_next_idx == IDX_W'(NUM_BLOCKS - 1)) w_state_nxt = DRAIN;
          end else begin
            w_gap_nxt = r_gap - GAP_W'(1);
          end
        end
      end
      DRAIN: begin
        w_ready_nxt = r_block_ready & ~end_level;
        if (r_block_ready == '0) w_state_nxt = r_level2 ? WIN : LEVEL_DONE;
      end
      LEVEL_DONE: begin
        if (w_run_edge) begin
          w_state_nxt  = SPAWN;
          w_level2_nxt = 1'b1;
          w_idx_nxt    = '0;
          w_gap_nxt    = GAP_W'(1);
        end
      end
      GAME_OVER, WIN: begin
        if (w_run_edge) begin
          w_state_nxt  = IDLE;
          w_level2_nxt = 1'b0;
          w_frame_nxt  = '0;
          w_sec_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Collision overrides any release or retirement decided this cycle.
    if (w_in_play && (Collision != 2'b00)) begin
      w_state_nxt = GAME_OVER;
      w_ready_nxt = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_block_ready <= '0;
      r_next_idx    <= '0;
      r_gap         <= '0;
      r_frame       <= '0;
      r_seconds     <= '0;
      r_level2      <= 1'b0;
      r_level_one   <= 1'b0;
      r_level_two   <= 1'b0;
      r_game_over   <= 1'b0;
      r_win         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_block_ready <= w_ready_nxt;
      r_next_idx    <= w_idx_nxt;
      r_gap         <= w_gap_nxt;
      r_frame       <= w_frame_nxt;
      r_seconds     <= w_sec_nxt;
      r_level2      <= w_level2_nxt;
      r_level_one   <= w_in_round_nxt & ~w_level2_nxt;
      r_level_two   <= w_in_round_nxt & w_level2_nxt;
      r_game_over   <= (w_state_nxt == GAME_OVER);
      r_win         <= (w_state_nxt == WIN);
    end
  end

  assign block_ready = r_block_ready;
  assign level_one   = r_level_one;
  assign level_two   = r_level_two;
  assign seconds     = r_seconds;
  assign game_over   = r_game_over;
  assign win         = r_win;

endmodule

// File: tb/tb_block_scheduler.sv
// Randomized scenario bench for block_scheduler against an event-level game model.
module tb_block_scheduler;

  localparam int NB = 10;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_DRAIN = 2, P_LDONE = 3, P_OVER = 4, P_WIN = 5;

  logic          Clk, Reset, vs, Run, run2;
  logic [1:0]    Collision;
  logic [NB-1:0] end_level;
  logic [NB-1:0] block_ready;
  logic          level_one, level_two, game_over, win;
  logic [9:0]    seconds;
  logic [1:0]    b2_ready;
  logic          b2_l1, b2_l2, b2_go, b2_win;
  logic [9:0]    b2_sec;

  int            n_pass, n_total;
  int            m_phase, m_level, m_lvl_ticks, m_play_ticks;
  logic [NB-1:0] m_inflight;
  logic          m_vs_prev, m_run_prev;

  block_scheduler dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .Run(Run), .Collision(Collision),
    .end_level(end_level), .block_ready(block_ready), .level_one(level_one),
    .level_two(level_two), .seconds(seconds), .game_over(game_over), .win(win)
  );

  // Small instance so seconds saturation is reachable quickly.
  block_scheduler #(.NUM_BLOCKS(2), .SPAWN_GAP(3), .FRAMES_PER_SEC(4), .SEC_MAX(5)) dut2 (
    .Clk(Clk), .Reset(Reset), .vs(vs), .Run(run2), .Collision(2'b00),
    .end_level(2'b00), .block_ready(b2_ready), .level_one(b2_l1),
    .level_two(b2_l2), .seconds(b2_sec), .game_over(b2_go), .win(b2_win)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic m_reset();
    m_phase = P_IDLE; m_level = 1; m_lvl_ticks = 0; m_play_ticks = 0;
    m_inflight = '0; m_vs_prev = 1'b1; m_run_prev = 1'b1;
  endtask

  // Game rules applied to one clock cycle of inputs.
  task automatic model_cycle(input logic v, input logic r, input logic [NB-1:0] e,
                             input logic [1:0] c);
    logic tick, rise, was_empty;
    int   gap, idx;
    tick = m_vs_prev && !v;
    rise = r && !m_run_prev;
    m_vs_prev = v; m_run_prev = r;
    if ((m_phase == P_SPAWN || m_phase == P_DRAIN) && tick) m_play_ticks++;
    case (m_phase)
      P_IDLE: if (rise) begin m_phase = P_SPAWN; m_level = 1; m_lvl_ticks = 0; end
      P_SPAWN, P_DRAIN: begin
        if (c != 2'b00) begin
          m_phase = P_OVER; m_inflight = '0;
        end else begin
          was_empty = (m_inflight == '0);
          m_inflight = m_inflight & ~e;
          if (m_phase == P_SPAWN && tick) begin
            m_lvl_ticks++;
            gap = (m_level == 1) ? 45 : 22;
            if ((m_lvl_ticks - 1) % gap == 0) begin
              idx = (m_lvl_ticks - 1) / gap;
              m_inflight[idx] = 1'b1;
              if (idx == NB - 1) m_phase = P_DRAIN;
            end
          end else if (m_phase == P_DRAIN && was_empty) begin
            m_phase = (m_level == 1) ? P_LDONE : P_WIN;
          end
        end
      end
      P_LDONE: if (rise) begin m_phase = P_SPAWN; m_level = 2; m_lvl_ticks = 0; end
      default: if (rise) begin m_phase = P_IDLE; m_level = 1; m_play_ticks = 0; end
    endcase
  endtask

  task automatic drive(input logic v, input logic r, input logic [NB-1:0] e,
                       input logic [1:0] c);
    vs = v; Run = r; end_level = e; Collision = c;
    @(posedge Clk);
    if (Reset) m_reset();
    else       model_cycle(v, r, e, c);
    #1;
  endtask

  function automatic logic [23:0] act_vec();
    return {block_ready, level_one, level_two, seconds, game_over, win};
  endfunction

  function automatic logic [23:0] exp_vec();
    int   sec;
    logic in_round;
    sec = m_play_ticks / 60;
    if (sec > 999) sec = 999;
    in_round = (m_phase == P_SPAWN) || (m_phase == P_DRAIN) || (m_phase == P_LDONE);
    return {m_inflight, in_round && (m_level == 1), in_round && (m_level == 2),
            10'(sec), m_phase == P_OVER, m_phase == P_WIN};
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) drive(1'b1, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_held got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    Reset = 1'b0;
    drive(1'b1, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_released got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_level_one();
    int order[NB];
    int j, tmp;
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    for (int t = 1; t <= 406; t++) begin
      drive(1'b0, 1'b0, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL lvl1_tick t=%0d got %h expected %h", t, act_vec(), exp_vec());
      else n_pass++;
      for (int k = $urandom_range(1, 3); k > 0; k--) begin
        drive(1'b1, 1'b0, (t == 50) ? NB'(10'h020) : '0, 2'b00);
        if (t == 50) begin
          n_total++;
          if (act_vec() !== exp_vec())
            $display("FAIL unreleased_end got %h expected %h", act_vec(), exp_vec());
          else n_pass++;
        end
      end
    end
    for (int i = 0; i < NB; i++) order[i] = i;
    for (int i = NB - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < NB; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, NB'(1) << order[i], 2'b00);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL lvl1_drain blk=%0d got %h expected %h", order[i], act_vec(), exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'(i % 2), 1'b0, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL lvl1_done c=%0d got %h expected %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_level_two();
    logic [NB-1:0] pending;
    int            idx;
    logic          rel;
    pending = '0;
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL lvl2_start got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    for (int t = 1; t <= 199; t++) begin
      rel = ((t - 1) % 22 == 0);
      idx = (t - 1) / 22;
      drive(1'b0, 1'b0, rel ? pending : '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL lvl2_tick t=%0d got %h expected %h", t, act_vec(), exp_vec());
      else n_pass++;
      if (rel) begin
        pending = '0;
        if (idx == NB - 1 || $urandom_range(0, 1) != 0) begin
          drive(1'b1, 1'b0, NB'(1) << idx, 2'b00);
          n_total++;
          if (act_vec() !== exp_vec())
            $display("FAIL lvl2_clear blk=%0d got %h expected %h", idx, act_vec(), exp_vec());
          else n_pass++;
        end else begin
          pending = NB'(1) << idx;
          drive(1'b1, 1'b0, '0, 2'b00);
        end
      end else begin
        drive(1'b1, 1'b0, '0, 2'b00);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL lvl2_win c=%0d got %h expected %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL win_to_idle got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_collision();
    int extra;
    extra = $urandom_range(0, 40);
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    for (int t = 1; t <= 91 + extra; t++) begin
      drive(1'b0, 1'b0, '0, 2'b00);
      drive(1'b1, 1'b0, '0, 2'b00);
    end
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL three_in_flight got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b0, '0, 2'b10);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL collision got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    for (int t = 0; t < 65; t++) begin
      drive(1'b0, 1'b0, '0, 2'b00);
      drive(1'b1, 1'b0, '0, 2'b00);
    end
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL sec_frozen got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL over_to_idle got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_collision_priority();
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    drive(1'b0, 1'b0, '0, 2'b00);
    drive(1'b1, 1'b0, NB'(1), 2'b01);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL coll_vs_end got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    drive(1'b0, 1'b0, '0, 2'b11);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL coll_vs_release got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
  endtask

  task automatic test_run_held();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL held_start c=%0d got %h expected %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b0, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b1, '0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL held_over c=%0d got %h expected %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b1, 1'b0, '0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, '0, 2'b00);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL held_idle c=%0d got %h expected %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b1, 1'b0, '0, 2'b00);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b0, '0, 2'b00);
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 1'b0, '0, 2'b00);
      drive(1'b1, 1'b0, '0, 2'b00);
    end
    drive(1'b1, 1'b1, '0, 2'b00);
    Reset = 1'b1;
    #2;
    m_reset();
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL async_reset got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b0, 1'b1, '0, 2'b00);
    drive(1'b0, 1'b1, '0, 2'b00);
    Reset = 1'b0;
    drive(1'b0, 1'b1, '0, 2'b00);
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b0, 1'b1, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL no_spurious_start got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b0, '0, 2'b00);
    drive(1'b1, 1'b1, '0, 2'b00);
    drive(1'b0, 1'b0, '0, 2'b00);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL restart_release got %h expected %h", act_vec(), exp_vec());
    else n_pass++;
    drive(1'b1, 1'b0, '0, 2'b00);
  endtask

  task automatic test_saturate();
    int exp_sec;
    run2 = 1'b1;
    drive(1'b1, 1'b0, '0, 2'b00);
    run2 = 1'b0;
    drive(1'b1, 1'b0, '0, 2'b00);
    for (int n = 1; n <= 28; n++) begin
      drive(1'b0, 1'b0, '0, 2'b00);
      drive(1'b1, 1'b0, '0, 2'b00);
      exp_sec = n / 4;
      if (exp_sec > 5) exp_sec = 5;
      n_total++;
      if (b2_sec !== 10'(exp_sec)) $display("FAIL sat_seconds n=%0d got %0d expected %0d", n, b2_sec, exp_sec);
      else n_pass++;
    end
    n_total++;
    if (b2_ready !== 2'b11) $display("FAIL sat_ready got %b expected 11", b2_ready);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    Reset = 1'b1; vs = 1'b1; Run = 1'b0; run2 = 1'b0;
    Collision = 2'b00; end_level = '0;
    m_reset();
    test_reset();
    test_level_one();
    test_level_two();
    test_collision();
    test_collision_priority();
    test_run_held();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
# block_scheduler

Sequencer for the falling-block game. Releases the ten blocks one at a time on frame boundaries, tracks each block until it finishes its fall, and advances level one to level two. It stops the round on any ball collision and keeps the elapsed-seconds count for the hex display. It sits between the frame sync from vga_controller, the two ball modules' collision outputs, and the block instances' block_ready/end_level handshake.

## Interface
Parameters:
- NUM_BLOCKS, 10, number of block instances scheduled
- SPAWN_GAP, 45, frame ticks between releases in level one; level two uses SPAWN_GAP/2 (integer divide)
- FRAMES_PER_SEC, 60, frame ticks per seconds increment
- SEC_MAX, 999, saturation value of seconds

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high; clears all state
- vs  in  1  vertical sync from vga_controller, active low, generated in the Clk domain
- Run  in  1  active-high start/advance request, level-sensitive, edge-detected internally
- Collision  in  2  per-ball collision flags, ORed internally
- end_level  in  NUM_BLOCKS  per-block fall-complete pulse/level
- block_ready  out  NUM_BLOCKS  per-block release; high while that block is in flight
- level_one, level_two  out  1  current level indicators, one-hot or both low
- seconds  out  10  elapsed whole seconds of the current round
- game_over  out  1  high in GAME_OVER
- win  out  1  high in WIN

## Operation
- States: IDLE, SPAWN, DRAIN, LEVEL_DONE, GAME_OVER, WIN.
- run_edge: Run high this cycle, low last cycle. tick: vs high last cycle, low this cycle (falling edge), one-cycle pulse.
- IDLE: outputs low, seconds=0, level=1. run_edge -> SPAWN, next_idx=0, gap counter loaded so the first release happens on the first tick.
- SPAWN: on tick, decrement gap counter; at zero set block_ready[next_idx], next_idx++, reload gap (SPAWN_GAP for level 1, SPAWN_GAP/2 for level 2). When next_idx reaches NUM_BLOCKS -> DRAIN.
- Any state in SPAWN/DRAIN: end_level[i] with block_ready[i]=1 clears block_ready[i]. end_level on an unreleased block is ignored.
- DRAIN: when block_ready==0 -> LEVEL_DONE if level 1, WIN if level 2.
- LEVEL_DONE: run_edge -> level=2, next_idx=0, -> SPAWN. seconds keeps counting across levels only while in SPAWN/DRAIN.
- Collision!=0 in SPAWN or DRAIN -> GAME_OVER, block_ready cleared to 0 the same transition.
- GAME_OVER/WIN: seconds frozen; run_edge -> IDLE.
- seconds: frame counter counts ticks in SPAWN/DRAIN; at FRAMES_PER_SEC-1 wraps to 0 and seconds++, saturating at SEC_MAX.
- level_one = (level==1) in SPAWN/DRAIN/LEVEL_DONE; level_two likewise for level 2; both low elsewhere.

## Timing
- Reset values: state IDLE, block_ready=0, level_one=level_two=0, seconds=0, game_over=0, win=0, internal counters 0, vs history register=1, Run history register=1. The Run history reset to 1 blocks a spurious start if Run is held through reset.
- All outputs registered. A tick in cycle n sets block_ready at cycle n+1.
- end_level sampled in cycle n clears block_ready at n+1. DRAIN exit is one cycle after the last clear.
- Collision sampled in cycle n: game_over=1 and block_ready=0 at n+1.
- Same cycle Collision and end_level: collision wins, GAME_OVER.
- Same cycle release tick and Collision: no release, GAME_OVER.
- Same cycle release and end_level on a different block: both take effect.
- Run held high: exactly one transition per rising edge.
- Reset asserted mid-round: all outputs return to reset values immediately, asynchronously.

## Structure
- Shared package game_pkg: state enum sched_state_t, NUM_BLOCKS, FRAMES_PER_SEC constants reused by block_SM and top level.
- One natural sub-module: edge_detect (registered previous value, rise/fall pulses) instantiated for vs and Run.
- Counters (gap, frame, seconds, next_idx) inline.

## Test plan
- Reset, pulse Run, drive ticks with end_level=0 -> block_ready[0] at first tick, block_ready[1] after 45 further ticks, all 10 set by tick 406, state DRAIN.
- Level one, pulse end_level[i] one cycle after each release -> LEVEL_DONE after last clear. Run -> level_two=1, releases every 22 ticks. Completing that level -> win=1.
- Collision=2'b10 while 3 blocks in flight -> next cycle game_over=1, block_ready=0, seconds frozen. Run -> IDLE, seconds=0.
- 120 ticks in SPAWN -> seconds=2. Force to 999, further 60 ticks -> stays 999.
- Collision and end_level[0] in the same cycle -> GAME_OVER; end_level[5] before block 5 is released -> no effect.
- Reset asserted mid-SPAWN with Run held high -> outputs zero at once; after Reset release no start until Run goes low then high.
